// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions used by the hazard control logic.
//   hz_state_e : registered hazard action of the previous cycle
//   hz_ctrl_t  : bundle of the pipeline-register enables and flushes
//   REG_X0     : architectural zero register (never a real dependency)
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_STALL = 2'd1,
        HZ_FLUSH    = 2'd2,
        HZ_MEM_WAIT = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_flush;
    } hz_ctrl_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // No hazard: everything advances, nothing is squashed.
    localparam hz_ctrl_t CTRL_DEFAULT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   inc        : add one this cycle unless already all-ones
//   clr        : synchronous clear, takes precedence over inc
//   count      : current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline, located in ID.
// Resolves load-use hazards (one-cycle bubble), taken branches resolved in
// EX (flush IF/ID and ID/EX) and data-memory busy (freeze everything).
// Priority: mem_busy > branch_taken_ex > load-use.
//   Inputs : IDEX_MemRead/IDEX_rd (EX instruction), IFID_rs1/rs2 and their
//            use flags (ID instruction), branch_taken_ex, mem_busy,
//            clear_counters (zeroes perf counters and timeout error)
//   Outputs: pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
//            idex_flush (combinational); hz_state (previous cycle's action);
//            mem_timeout_err (sticky); stall_cycles, flush_events,
//            loaduse_events (saturating counters)
module hazard_control_unit
    import riscv_pipe_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int WAIT_W      = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rd,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             IFID_use_rs1,
    input  logic             IFID_use_rs2,
    input  logic             branch_taken_ex,
    input  logic             mem_busy,
    input  logic             clear_counters,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       hz_state,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] loaduse_events
);

    hz_state_e        state_q, state_d;
    hz_ctrl_t         ctrl;
    logic             lu;
    logic             win_mem, win_br, win_lu;
    logic [WAIT_W-1:0] wait_cnt;

    // x0 writes are discarded, so a load into x0 never creates a dependency.
    assign lu = IDEX_MemRead && (IDEX_rd != REG_X0) &&
                (((IDEX_rd == IFID_rs1) && IFID_use_rs1) ||
                 ((IDEX_rd == IFID_rs2) && IFID_use_rs2));

    assign win_mem = mem_busy;
    assign win_br  = !mem_busy && branch_taken_ex;
    // A branch in EX makes the ID instruction wrong-path, so its lu is moot.
    assign win_lu  = !mem_busy && !branch_taken_ex && lu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= HZ_RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        ctrl    = CTRL_DEFAULT;
        state_d = HZ_RUN;
        if (!rst_n) begin
            // Hold the pipe and squash IF/ID, ID/EX while in reset.
            ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        end else if (win_mem) begin
            // Freeze; a pending branch/lu is simply re-seen once memory is ready.
            ctrl    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            state_d = HZ_MEM_WAIT;
        end else if (win_br) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            state_d         = HZ_FLUSH;
        end else if (win_lu) begin
            // Hold PC and IF/ID, send a bubble into EX; the load moves on.
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.idex_flush = 1'b1;
            state_d         = HZ_LU_STALL;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign idex_write  = ctrl.idex_write;
    assign exmem_write = ctrl.exmem_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign hz_state    = state_q;

    // Consecutive busy cycles; any ready cycle restarts the count.
    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mem_busy),
        .clr   (!mem_busy),
        .count (wait_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_timeout_err <= 1'b0;
        else if (clear_counters)
            mem_timeout_err <= 1'b0;
        else if (mem_busy && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)))
            mem_timeout_err <= 1'b1;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (win_mem || win_lu),
        .clr   (clear_counters),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (win_br),
        .clr   (clear_counters),
        .count (flush_events)
    );

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (win_lu),
        .clr   (clear_counters),
        .count (loaduse_events)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (CNT_W=4, MEM_TIMEOUT=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_rd, IFID_rs1, IFID_rs2;
    logic       IFID_use_rs1, IFID_use_rs2;
    logic       branch_taken_ex, mem_busy, clear_counters;
    logic       pc_write, ifid_write, idex_write, exmem_write;
    logic       ifid_flush, idex_flush;
    logic [1:0] hz_state;
    logic       mem_timeout_err;
    logic [3:0] stall_cycles, flush_events, loaduse_events;

    int total = 0;
    int bad   = 0;

    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush}
    logic [5:0] ctl;
    assign ctl = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush};

    localparam logic [5:0] C_DEF = 6'b111100;
    localparam logic [5:0] C_RST = 6'b000011;
    localparam logic [5:0] C_LU  = 6'b001101;
    localparam logic [5:0] C_BR  = 6'b111111;
    localparam logic [5:0] C_FRZ = 6'b000000;

    hazard_control_unit #(.CNT_W(4), .WAIT_W(8), .MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IDEX_MemRead    (IDEX_MemRead),
        .IDEX_rd         (IDEX_rd),
        .IFID_rs1        (IFID_rs1),
        .IFID_rs2        (IFID_rs2),
        .IFID_use_rs1    (IFID_use_rs1),
        .IFID_use_rs2    (IFID_use_rs2),
        .branch_taken_ex (branch_taken_ex),
        .mem_busy        (mem_busy),
        .clear_counters  (clear_counters),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .exmem_write     (exmem_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .hz_state        (hz_state),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
        .loaduse_events  (loaduse_events)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        IDEX_MemRead = 0; IDEX_rd = 0; IFID_rs1 = 0; IFID_rs2 = 0;
        IFID_use_rs1 = 0; IFID_use_rs2 = 0;
        branch_taken_ex = 0; mem_busy = 0; clear_counters = 0;
    endtask

    task automatic set_lu();
        IDEX_MemRead = 1; IDEX_rd = 5; IFID_rs1 = 5; IFID_use_rs1 = 1;
        IFID_rs2 = 0; IFID_use_rs2 = 0;
    endtask

    // Drive one idle cycle with clear_counters high.
    task automatic do_clear();
        @(negedge clk); set_idle(); clear_counters = 1;
        @(negedge clk); clear_counters = 0;
    endtask

    task automatic test_reset();
        set_idle(); rst_n = 0;
        #2;
        total++; if (ctl !== C_RST) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST); end
        total++; if (hz_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", hz_state); end
        total++; if ({stall_cycles, flush_events, loaduse_events, mem_timeout_err} !== 13'd0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d/%0d/%0d exp=0", stall_cycles, flush_events, loaduse_events, mem_timeout_err); end
        @(negedge clk); rst_n = 1; #1;
        total++; if (ctl !== C_DEF) begin bad++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, C_DEF); end
    endtask

    task automatic test_load_use();
        do_clear();
        set_lu(); #1;
        total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_ctl got=%b exp=%b", ctl, C_LU); end
        @(negedge clk); IDEX_MemRead = 0; #1;
        total++; if (ctl !== C_DEF) begin bad++; $display("FAIL lu_next_ctl got=%b exp=%b", ctl, C_DEF); end
        total++; if (hz_state !== 2'd1) begin bad++; $display("FAIL lu_state got=%0d exp=1", hz_state); end
        total++; if (loaduse_events !== 4'd1 || stall_cycles !== 4'd1) begin
            bad++; $display("FAIL lu_counts got=lu%0d/st%0d exp=1/1", loaduse_events, stall_cycles); end
        @(negedge clk); #1;
        total++; if (hz_state !== 2'd0) begin bad++; $display("FAIL lu_back_run got=%0d exp=0", hz_state); end
    endtask

    task automatic test_no_false_stall();
        do_clear();
        set_lu(); IDEX_rd = 0; IFID_rs1 = 0; #1;
        total++; if (ctl !== C_DEF) begin bad++; $display("FAIL nofs_x0 got=%b exp=%b", ctl, C_DEF); end
        @(negedge clk); set_lu(); IFID_rs1 = 3; IFID_rs2 = 5; IFID_use_rs2 = 0; #1;
        total++; if (ctl !== C_DEF) begin bad++; $display("FAIL nofs_unused_rs2 got=%b exp=%b", ctl, C_DEF); end
        @(negedge clk); IFID_use_rs2 = 1; #1;
        total++; if (ctl !== C_LU) begin bad++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU); end
        @(negedge clk); set_idle(); #1;
        total++; if (loaduse_events !== 4'd1) begin bad++; $display("FAIL nofs_count got=%0d exp=1", loaduse_events); end
    endtask

    task automatic test_branch_beats_lu();
        do_clear();
        set_lu(); branch_taken_ex = 1; #1;
        total++; if (ctl !== C_BR) begin bad++; $display("FAIL br_ctl got=%b exp=%b", ctl, C_BR); end
        @(negedge clk); set_idle(); #1;
        total++; if (flush_events !== 4'd1 || loaduse_events !== 4'd0 || stall_cycles !== 4'd0) begin
            bad++; $display("FAIL br_counts got=fl%0d/lu%0d/st%0d exp=1/0/0", flush_events, loaduse_events, stall_cycles); end
        total++; if (hz_state !== 2'd2) begin bad++; $display("FAIL br_state got=%0d exp=2", hz_state); end
    endtask

    task automatic test_mem_freeze();
        do_clear();
        for (int i = 0; i < 4; i++) begin
            mem_busy = 1; branch_taken_ex = 1; set_lu(); #1;
            total++; if (ctl !== C_FRZ) begin bad++; $display("FAIL frz_ctl[%0d] got=%b exp=%b", i, ctl, C_FRZ); end
            total++; if (mem_timeout_err !== 1'b0) begin bad++; $display("FAIL frz_err_early[%0d] got=%b exp=0", i, mem_timeout_err); end
            @(negedge clk);
        end
        mem_busy = 0; #1;
        total++; if (ctl !== C_BR) begin bad++; $display("FAIL frz_release_ctl got=%b exp=%b", ctl, C_BR); end
        total++; if (mem_timeout_err !== 1'b1) begin bad++; $display("FAIL frz_timeout got=%b exp=1", mem_timeout_err); end
        total++; if (stall_cycles !== 4'd4 || hz_state !== 2'd3) begin
            bad++; $display("FAIL frz_stall got=st%0d/hz%0d exp=4/3", stall_cycles, hz_state); end
        @(negedge clk); set_idle(); #1;
        total++; if (flush_events !== 4'd1 || hz_state !== 2'd2 || mem_timeout_err !== 1'b1) begin
            bad++; $display("FAIL frz_after got=fl%0d/hz%0d/err%b exp=1/2/1", flush_events, hz_state, mem_timeout_err); end
    endtask

    task automatic test_saturation_clear();
        int exp_cnt;
        do_clear();
        for (int i = 0; i < 20; i++) begin
            set_lu(); #1;
            exp_cnt = (i > 15) ? 15 : i;
            total++; if (loaduse_events !== 4'(exp_cnt)) begin
                bad++; $display("FAIL sat_lu[%0d] got=%0d exp=%0d", i, loaduse_events, exp_cnt); end
            @(negedge clk);
        end
        clear_counters = 1; #1;
        total++; if (loaduse_events !== 4'd15 || stall_cycles !== 4'd15) begin
            bad++; $display("FAIL sat_hold got=lu%0d/st%0d exp=15/15", loaduse_events, stall_cycles); end
        @(negedge clk); set_idle(); #1;
        total++; if (loaduse_events !== 4'd0 || stall_cycles !== 4'd0 || mem_timeout_err !== 1'b0) begin
            bad++; $display("FAIL sat_clear got=lu%0d/st%0d/err%b exp=0/0/0", loaduse_events, stall_cycles, mem_timeout_err); end
        total++; if (hz_state !== 2'd1) begin bad++; $display("FAIL clear_keeps_state got=%0d exp=1", hz_state); end
    endtask

    task automatic test_async_reset();
        set_idle(); mem_busy = 1;
        @(negedge clk); @(negedge clk);
        #2 rst_n = 0; #1;
        total++; if (ctl !== C_RST) begin bad++; $display("FAIL arst_ctl got=%b exp=%b", ctl, C_RST); end
        total++; if (hz_state !== 2'd0 || stall_cycles !== 4'd0) begin
            bad++; $display("FAIL arst_regs got=hz%0d/st%0d exp=0/0", hz_state, stall_cycles); end
        @(negedge clk); set_idle(); rst_n = 1; #1;
        total++; if (ctl !== C_DEF) begin bad++; $display("FAIL arst_release got=%b exp=%b", ctl, C_DEF); end
        @(negedge clk); #1;
        total++; if (hz_state !== 2'd0) begin bad++; $display("FAIL arst_state got=%0d exp=0", hz_state); end
    endtask

    // Two 3-cycle busy bursts split by one ready cycle must not time out.
    task automatic test_wait_restart();
        set_idle();
        for (int i = 0; i < 7; i++) begin
            mem_busy = (i != 3);
            @(negedge clk);
        end
        set_idle(); #1;
        total++; if (mem_timeout_err !== 1'b0) begin bad++; $display("FAIL wait_restart got=%b exp=0", mem_timeout_err); end
        total++; if (stall_cycles !== 4'd6) begin bad++; $display("FAIL wait_stalls got=%0d exp=6", stall_cycles); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_branch_beats_lu();
        test_mem_freeze();
        test_saturation_clear();
        test_async_reset();
        test_wait_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
